// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard inputs and per-stage pipeline controls of the stall controller.
// master = pipeline/hazard side, slave = stall controller.
interface pipeline_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             LoadSlot;
  logic             BranchSlot;
  logic             IF_Conflict;
  logic             Mem_Ready;
  logic             PC_Write;
  logic             PC_SelBranch;
  logic             IFID_Write;
  logic             IFID_Flush;
  logic             IDEXE_Flush;
  logic             Pipe_Freeze;
  logic [CNT_W-1:0] Bubble_Count;
  logic [CNT_W-1:0] Flush_Count;
  logic             Timeout_Err;

  // Level signals, no valid/ready: every input is sampled every cycle and
  // every control output is meaningful every cycle.
  modport master (
    output LoadSlot, BranchSlot, IF_Conflict, Mem_Ready,
    input  PC_Write, PC_SelBranch, IFID_Write, IFID_Flush, IDEXE_Flush,
           Pipe_Freeze, Bubble_Count, Flush_Count, Timeout_Err
  );

  modport slave (
    input  LoadSlot, BranchSlot, IF_Conflict, Mem_Ready,
    output PC_Write, PC_SelBranch, IFID_Write, IFID_Flush, IDEXE_Flush,
           Pipe_Freeze, Bubble_Count, Flush_Count, Timeout_Err
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush/freeze controller for a 5-stage pipeline: Mealy controls from
// hazards, a memory-wait/load-hold FSM and saturating debug counters.
module pipeline_stall_ctrl #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_stall_ctrl_if.slave bus,
  output logic [1:0]           state_dbg_o
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MEM_WAIT  = 2'd1,
    LOAD_HOLD = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]    bubble_q, bubble_d;
  logic [CNT_W-1:0]    flush_q, flush_d;
  logic                timeout_q, timeout_d;

  logic pc_we, pc_sel, ifid_we, ifid_fl, idexe_fl, freeze;
  logic bubble_inc, flush_inc, apply_rows;

  always_comb begin
    pc_we      = 1'b1;
    pc_sel     = 1'b0;
    ifid_we    = 1'b1;
    ifid_fl    = 1'b0;
    idexe_fl   = 1'b0;
    freeze     = 1'b0;
    state_d    = RUN;
    wait_d     = '0;
    timeout_d  = timeout_q;
    bubble_inc = 1'b0;
    flush_inc  = 1'b0;
    apply_rows = 1'b0;

    if (!bus.Mem_Ready) begin
      if (state_q != MEM_WAIT) begin
        freeze  = 1'b1;
        pc_we   = 1'b0;
        ifid_we = 1'b0;
        state_d = MEM_WAIT;
        wait_d  = WAIT_W'(1);
      end else if (wait_q < WAIT_W'(MAX_WAIT)) begin
        freeze  = 1'b1;
        pc_we   = 1'b0;
        ifid_we = 1'b0;
        state_d = MEM_WAIT;
        wait_d  = wait_q + WAIT_W'(1);
      end else begin
        // Forced release: let the pipeline move and flag the stuck access.
        timeout_d = 1'b1;
      end
    end else begin
      apply_rows = 1'b1;
    end

    // The load that caused LOAD_HOLD has already been bubbled once.
    if (apply_rows) begin
      if (bus.BranchSlot) begin
        pc_sel    = 1'b1;
        ifid_fl   = 1'b1;
        idexe_fl  = 1'b1;
        flush_inc = 1'b1;
      end else if (bus.LoadSlot && state_q != LOAD_HOLD) begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        idexe_fl   = 1'b1;
        bubble_inc = 1'b1;
        state_d    = LOAD_HOLD;
      end else if (bus.IF_Conflict) begin
        pc_we      = 1'b0;
        ifid_fl    = 1'b1;
        bubble_inc = 1'b1;
      end
    end

    bubble_d = (bubble_inc && bubble_q != '1) ? bubble_q + CNT_W'(1) : bubble_q;
    flush_d  = (flush_inc && flush_q != '1) ? flush_q + CNT_W'(1) : flush_q;

    // Reset forces the pipeline to flush, independent of the clock.
    if (!rst) begin
      pc_we    = 1'b0;
      pc_sel   = 1'b0;
      ifid_we  = 1'b0;
      ifid_fl  = 1'b1;
      idexe_fl = 1'b1;
      freeze   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      wait_q    <= '0;
      bubble_q  <= '0;
      flush_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bubble_q  <= bubble_d;
      flush_q   <= flush_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.PC_Write     = pc_we;
  assign bus.PC_SelBranch = pc_sel;
  assign bus.IFID_Write   = ifid_we;
  assign bus.IFID_Flush   = ifid_fl;
  assign bus.IDEXE_Flush  = idexe_fl;
  assign bus.Pipe_Freeze  = freeze;
  assign bus.Bubble_Count = bubble_q;
  assign bus.Flush_Count  = flush_q;
  assign bus.Timeout_Err  = timeout_q;
  assign state_dbg_o      = state_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: wide-counter and 2-bit-counter instances
// driven identically and scored against a behavioural model.
module tb_pipeline_stall_ctrl;

  localparam int MAX_WAIT = 15;
  // {PC_Write, PC_SelBranch, IFID_Write, IFID_Flush, IDEXE_Flush, Pipe_Freeze}
  localparam logic [5:0] C_NORMAL = 6'b101000;
  localparam logic [5:0] C_FREEZE = 6'b000001;
  localparam logic [5:0] C_BRANCH = 6'b111110;
  localparam logic [5:0] C_LOAD   = 6'b000010;
  localparam logic [5:0] C_IFC    = 6'b001100;
  localparam logic [5:0] C_RESET  = 6'b000110;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] dbg_w, dbg_s;

  pipeline_stall_ctrl_if #(.CNT_W(16)) bus_w ();
  pipeline_stall_ctrl_if #(.CNT_W(2))  bus_s ();

  pipeline_stall_ctrl #(.CNT_W(16), .MAX_WAIT(MAX_WAIT), .WAIT_W(4)) dut_w (
    .clk(clk), .rst(rst), .bus(bus_w.slave), .state_dbg_o(dbg_w)
  );
  pipeline_stall_ctrl #(.CNT_W(2), .MAX_WAIT(MAX_WAIT), .WAIT_W(4)) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s.slave), .state_dbg_o(dbg_s)
  );

  always #5 clk = ~clk;

  int checks_n   = 0;
  int failures_n = 0;

  logic [5:0]  exp_q[$];
  logic [38:0] cnt_q[$];

  // Behavioural model state
  int m_state = 0;  // 0 RUN, 1 MEM_WAIT, 2 LOAD_HOLD
  int m_wait  = 0;
  int m_bub   = 0;
  int m_fl    = 0;
  int m_bub_s = 0;
  int m_fl_s  = 0;
  int m_to    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_n++;
    if (got !== exp) begin
      failures_n++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] ctrl_w();
    return {bus_w.PC_Write, bus_w.PC_SelBranch, bus_w.IFID_Write,
            bus_w.IFID_Flush, bus_w.IDEXE_Flush, bus_w.Pipe_Freeze};
  endfunction

  function automatic logic [5:0] ctrl_s();
    return {bus_s.PC_Write, bus_s.PC_SelBranch, bus_s.IFID_Write,
            bus_s.IFID_Flush, bus_s.IDEXE_Flush, bus_s.Pipe_Freeze};
  endfunction

  task automatic model_reset();
    m_state = 0; m_wait = 0; m_bub = 0; m_fl = 0;
    m_bub_s = 0; m_fl_s = 0; m_to = 0;
  endtask

  task automatic bump_bubble();
    if (m_bub < 65535) m_bub++;
    if (m_bub_s < 3) m_bub_s++;
  endtask

  task automatic bump_flush();
    if (m_fl < 65535) m_fl++;
    if (m_fl_s < 3) m_fl_s++;
  endtask

  // Returns the expected controls and advances the model to the post-edge state.
  task automatic model_step(input logic ld, br, ifc, mr, output logic [5:0] c);
    int ns;
    logic rows;
    ns = 0;
    rows = 1'b0;
    c = C_NORMAL;
    if (!mr && m_state == 1 && m_wait >= MAX_WAIT) begin
      m_to = 1; m_wait = 0;
    end else if (!mr) begin
      c = C_FREEZE; ns = 1;
      m_wait = (m_state == 1) ? m_wait + 1 : 1;
    end else begin
      rows = 1'b1; m_wait = 0;
    end
    if (rows) begin
      if (br) begin
        c = C_BRANCH; bump_flush();
      end else if (ld && m_state != 2) begin
        c = C_LOAD; bump_bubble(); ns = 2;
      end else if (ifc) begin
        c = C_IFC; bump_bubble();
      end
    end
    m_state = ns;
  endtask

  task automatic drive(input logic ld, br, ifc, mr);
    bus_w.LoadSlot = ld; bus_w.BranchSlot = br; bus_w.IF_Conflict = ifc; bus_w.Mem_Ready = mr;
    bus_s.LoadSlot = ld; bus_s.BranchSlot = br; bus_s.IF_Conflict = ifc; bus_s.Mem_Ready = mr;
  endtask

  task automatic check_regs(input string tag);
    logic [38:0] e;
    e = cnt_q.pop_front();
    check({tag, "_bub"},   32'(bus_w.Bubble_Count), 32'(e[38:23]));
    check({tag, "_fl"},    32'(bus_w.Flush_Count),  32'(e[22:7]));
    check({tag, "_bub_s"}, 32'(bus_s.Bubble_Count), 32'(e[6:5]));
    check({tag, "_fl_s"},  32'(bus_s.Flush_Count),  32'(e[4:3]));
    check({tag, "_to"},    32'(bus_w.Timeout_Err),  32'(e[2]));
    check({tag, "_state"}, 32'(dbg_w),              32'(e[1:0]));
  endtask

  task automatic push_regs();
    cnt_q.push_back({16'(m_bub), 16'(m_fl), 2'(m_bub_s), 2'(m_fl_s), 1'(m_to), 2'(m_state)});
  endtask

  // One clock: drive at the falling edge, check Mealy controls before the
  // rising edge, then registered state just after it.
  task automatic step(input string tag, input logic ld, br, ifc, mr);
    logic [5:0] c;
    logic [5:0] e;
    @(negedge clk);
    drive(ld, br, ifc, mr);
    model_step(ld, br, ifc, mr, c);
    exp_q.push_back(c);
    push_regs();
    #1;
    e = exp_q.pop_front();
    check({tag, "_ctrl"},   32'(ctrl_w()), 32'(e));
    check({tag, "_ctrl_s"}, 32'(ctrl_s()), 32'(e));
    @(posedge clk);
    #1;
    check_regs(tag);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    rst = 1'b0;
    model_reset();
    exp_q.push_back(C_RESET);
    push_regs();
    #1;
    check({tag, "_ctrl"}, 32'(ctrl_w()), 32'(exp_q.pop_front()));
    check_regs(tag);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    exp_q.push_back(C_RESET);
    push_regs();
    check("por_ctrl", 32'(ctrl_w()), 32'(exp_q.pop_front()));
    check_regs("por");
    @(negedge clk);
    rst = 1'b1;

    step("idle", 1'b0, 1'b0, 1'b0, 1'b1);

    // Two-cycle LoadSlot: bubble, then LOAD_HOLD passes through normally.
    step("load1", 1'b1, 1'b0, 1'b0, 1'b1);
    step("load2", 1'b1, 1'b0, 1'b0, 1'b1);

    // Branch wins over load.
    step("brld", 1'b1, 1'b1, 1'b0, 1'b1);

    // Three wait cycles then a fetch conflict on release.
    for (int i = 0; i < 3; i++) step("wait3", 1'b0, 1'b0, 1'b0, 1'b0);
    step("wait3_rel", 1'b0, 1'b0, 1'b1, 1'b1);

    // Load during LOAD_HOLD with memory stalled goes straight to MEM_WAIT.
    step("ldh_a", 1'b1, 1'b0, 1'b0, 1'b1);
    step("ldh_b", 1'b1, 1'b0, 1'b0, 1'b0);
    step("ldh_c", 1'b1, 1'b0, 1'b0, 1'b1);
    step("ldh_d", 1'b0, 1'b0, 1'b0, 1'b1);

    // Timeout: 15 frozen cycles, release on the 16th, flag stays set.
    for (int i = 0; i < MAX_WAIT + 1; i++) step("tmo", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("tmo_after", 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset while waiting on memory.
    step("pre_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    step("pre_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset("mid_wait_rst");
    step("post_rst", 1'b0, 1'b0, 1'b0, 1'b1);

    // 2-bit counters saturate at 3.
    for (int i = 0; i < 5; i++) begin
      step("sat_ifc", 1'b0, 1'b0, 1'b1, 1'b1);
      step("sat_gap", 1'b0, 1'b0, 1'b0, 1'b1);
    end
    for (int i = 0; i < 4; i++) step("sat_br", 1'b0, 1'b1, 1'b0, 1'b1);

    // Randomised mix of all hazards.
    for (int i = 0; i < 400; i++) begin
      step("rnd",
           1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 4) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks_n, failures_n);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Consumer of the hazard unit's LoadSlot and BranchSlot outputs.
- Turns hazard indications, plus instruction-RAM structural conflicts and multi-cycle data-memory waits, into per-stage write-enable, flush and freeze controls for the 5-stage MIPS16-style pipeline (IF/ID/EXE/MEM/WB).
- Holds a small FSM for memory waits and post-load masking, plus saturating debug counters for bubbles and flushes.

Parameters:
- CNT_W, 16: width of Bubble_Count and Flush_Count.
- MAX_WAIT, 15: maximum consecutive MEM_WAIT cycles before forced release. Must be ≥1.
- WAIT_W, 4: width of the internal wait counter. Must hold MAX_WAIT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- LoadSlot  in  1  load-use hazard: EXE is a load and ID needs its result.
- BranchSlot  in  1  taken branch/jump resolved in MEM.
- IF_Conflict  in  1  MEM stage uses instruction RAM this cycle, so the IF fetch is lost.
- Mem_Ready  in  1  MEM-stage data access completes this cycle. Tied to 1 for single-cycle memory.
- PC_Write  out  1  PC register write enable.
- PC_SelBranch  out  1  select branch target as next PC.
- IFID_Write  out  1  IF/ID register write enable.
- IFID_Flush  out  1  load NOP into IF/ID.
- IDEXE_Flush  out  1  load NOP (bubble) into ID/EXE.
- Pipe_Freeze  out  1  hold ID/EXE, EXE/MEM and MEM/WB registers.
- Bubble_Count  out  CNT_W  saturating count of bubbles inserted.
- Flush_Count  out  CNT_W  saturating count of branch flushes.
- Timeout_Err  out  1  sticky flag: a MEM_WAIT timed out.

Behaviour:
- States: RUN, MEM_WAIT, LOAD_HOLD.
  - Registered: state, wait_cnt, both counters, Timeout_Err.
  - Control outputs are combinational (Mealy) from state and inputs, so they take effect in the same cycle as the hazard.
- Reset (rst=0, asynchronous):
  - state=RUN, wait_cnt=0, counters=0, Timeout_Err=0.
  - While rst=0: PC_Write=0, IFID_Write=0, IFID_Flush=1, IDEXE_Flush=1, PC_SelBranch=0, Pipe_Freeze=0.
  - Reset mid-wait or mid-hold aborts immediately to the above.
- Default ("normal") outputs: PC_Write=1, IFID_Write=1, all others 0.
- Decision rule D, applied in RUN. First matching row wins.
  1. Mem_Ready=0:
     - Outputs: Pipe_Freeze=1, PC_Write=0, IFID_Write=0, no flushes.
     - Next: MEM_WAIT, wait_cnt=1.
  2. BranchSlot=1:
     - Outputs: PC_Write=1, PC_SelBranch=1, IFID_Write=1, IFID_Flush=1, IDEXE_Flush=1.
     - Flush_Count+1. Next: RUN.
  3. LoadSlot=1 (whether or not IF_Conflict is set):
     - Outputs: PC_Write=0, IFID_Write=0, IDEXE_Flush=1.
     - Bubble_Count+1. Next: LOAD_HOLD.
  4. IF_Conflict=1:
     - Outputs: PC_Write=0, IFID_Write=1, IFID_Flush=1.
     - Bubble_Count+1. Next: RUN.
  5. Otherwise: normal outputs. Next: RUN.
- MEM_WAIT:
  - If Mem_Ready=0 and wait_cnt<MAX_WAIT: freeze outputs as D row 1; wait_cnt+1; stay in MEM_WAIT.
  - If Mem_Ready=0 and wait_cnt==MAX_WAIT: normal outputs, Timeout_Err←1, next RUN, wait_cnt←0.
  - If Mem_Ready=1: apply D rows 2–5 in that cycle, wait_cnt←0.
- LOAD_HOLD:
  - Lasts exactly one cycle.
  - Applies D with LoadSlot treated as 0; every other input is honoured, including Mem_Ready=0, which goes to MEM_WAIT.
  - If no other row fires, next state is RUN.
- Counters saturate at all-ones and never wrap. Both counters may update in the same cycle only if the rules allow it; they do not by construction.
- Timeout_Err is cleared only by reset.

Test Plan:
- rst pulses low mid-cycle while in MEM_WAIT → outputs go to reset values immediately; after release with no hazards: PC_Write=1, IFID_Write=1, counters=0.
- LoadSlot=1 for 2 consecutive cycles → cycle 1: PC_Write=0, IFID_Write=0, IDEXE_Flush=1, Bubble_Count=1; cycle 2 (LOAD_HOLD): normal outputs, Bubble_Count stays 1.
- BranchSlot=1 together with LoadSlot=1 → PC_SelBranch=1, IFID_Flush=1, IDEXE_Flush=1, Flush_Count=1, Bubble_Count=0, next state RUN.
- Mem_Ready=0 for 3 cycles, then 1 with IF_Conflict=1 → Pipe_Freeze=1 for 3 cycles; 4th cycle: Pipe_Freeze=0, PC_Write=0, IFID_Flush=1, Bubble_Count=1.
- MAX_WAIT=15, Mem_Ready held 0 → freeze for 15 cycles; 16th cycle: normal outputs and Timeout_Err=1, which stays 1 after Mem_Ready returns.
- CNT_W=2, 5 isolated IF_Conflict pulses → Bubble_Count reads 1, 2, 3, 3, 3.
